fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 36 +++
 rtl/fetch_unit_buffer.sv | 55 +++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: decode mode codes, FSM state encoding,
// bubble default and prefetch depth (define FETCH_PREFETCH_EN for a 2-entry buffer, else 1).
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        MODE_STALL  = 2'd0,
        MODE_NORMAL = 2'd1,
        MODE_BRANCH = 2'd2
    } mode_e;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_WAIT = 2'd2;
    localparam fetch_state_t ST_DROP = 2'd3;

    localparam logic [15:0] NOP_IR_DEFAULT = 16'hBF00;

`ifdef FETCH_PREFETCH_EN
    localparam int FETCH_BUF_DEPTH = 2;
`else
    localparam int FETCH_BUF_DEPTH = 1;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ir;
    } fetch_entry_t;

    // Instruction addresses are halfword aligned; bit 0 is never honoured.
    function automatic logic [31:0] halfword_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFE;
    endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// Small FIFO holding fetched {pc, instruction} pairs between memory and the instruction register.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) return '0;
        return ptr + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Flush discards everything at once, so it shares the reset path for the pointers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues halfword fetches, buffers returned data and feeds decode.
// Define FETCH_PREFETCH_EN to overlap fetching with consumption via a 2-deep prefetch buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [15:0] NOP_IR   = NOP_IR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_mode,
    input  logic [31:0] i_branch_addr,
    output logic [31:0] o_imem_addr_r,
    output logic        o_imem_req_r,
    input  logic [15:0] i_imem_rdata,
    input  logic        i_imem_ack,
    output logic [15:0] o_ir_r,
    output logic [31:0] o_pc_r,
    output logic        o_ir_valid_r
);
    localparam int CNT_W = $clog2(FETCH_BUF_DEPTH + 1);

    fetch_state_t     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      branch_target;
    logic             is_branch;
    logic             is_normal;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_full;
    logic             buf_empty;
    logic             fills_buffer;
    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_wdata;
    fetch_entry_t     buf_rdata;

    assign is_branch     = (i_mode == MODE_BRANCH);
    assign is_normal     = (i_mode == MODE_NORMAL);
    assign branch_target = halfword_align(i_branch_addr);
    assign buf_pop       = is_normal && !buf_empty;
    assign buf_push      = (state == ST_WAIT) && i_imem_ack && !is_branch;
    assign buf_wdata     = '{pc: fetch_pc, ir: i_imem_rdata};

    // The outstanding request always owns a free slot, so only the ack can fill the buffer.
    assign fills_buffer  = (int'(buf_count) + 1 - int'(buf_pop)) >= FETCH_BUF_DEPTH;

    fetch_buffer #(
        .DEPTH(FETCH_BUF_DEPTH)
    ) u_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (is_branch),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    // A branch redirects fetch_pc from any state; data acked alongside it is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            fetch_pc      <= RESET_PC;
            o_imem_req_r  <= 1'b0;
            o_imem_addr_r <= RESET_PC;
        end else begin
            if (is_branch) fetch_pc <= branch_target;
            case (state)
                ST_IDLE: begin
                    if (is_branch || !buf_full) state <= ST_REQ;
                end
                ST_REQ: begin
                    o_imem_req_r  <= 1'b1;
                    o_imem_addr_r <= is_branch ? branch_target : fetch_pc;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_imem_ack) begin
                        o_imem_req_r <= 1'b0;
                        if (is_branch) begin
                            state <= ST_REQ;
                        end else begin
                            fetch_pc <= fetch_pc + 32'd2;
                            state    <= fills_buffer ? ST_IDLE : ST_REQ;
                        end
                    end else if (is_branch) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (i_imem_ack) begin
                        o_imem_req_r <= 1'b0;
                        state        <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decode sees a bubble whenever nothing is buffered; stalls freeze the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ir_r       <= NOP_IR;
            o_pc_r       <= RESET_PC;
            o_ir_valid_r <= 1'b0;
        end else if (is_branch) begin
            o_ir_r       <= NOP_IR;
            o_ir_valid_r <= 1'b0;
        end else if (is_normal) begin
            if (!buf_empty) begin
                o_ir_r       <= buf_rdata.ir;
                o_pc_r       <= buf_rdata.pc;
                o_ir_valid_r <= 1'b1;
            end else begin
                o_ir_r       <= NOP_IR;
                o_ir_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by randomized mode traffic.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [15:0] NOP    = 16'hBF00;
`ifdef FETCH_PREFETCH_EN
    localparam int EXP_DEPTH = 2;
`else
    localparam int EXP_DEPTH = 1;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  i_mode = MODE_STALL;
    logic [31:0] i_branch_addr = '0;
    logic [31:0] o_imem_addr_r;
    logic        o_imem_req_r;
    logic [15:0] i_imem_rdata = '0;
    logic        i_imem_ack = 1'b0;
    logic [15:0] o_ir_r;
    logic [31:0] o_pc_r;
    logic        o_ir_valid_r;

    int total = 0;
    int bad = 0;
    int delivered = 0;

    exp_t        exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] req_log[$];
    logic [15:0] model_ir = NOP;
    logic [31:0] model_pc = RST_PC;
    logic        model_valid = 1'b0;
    logic        s_rst = 1'b0;
    logic [1:0]  s_mode = MODE_STALL;
    bit          started = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;

    bit mem_en = 1'b1;
    int lat_min = 0;
    int lat_max = 0;
    int wait_cnt = 0;
    bit counting = 1'b0;

    fetch_unit #(
        .RESET_PC(RST_PC),
        .NOP_IR  (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mode       (i_mode),
        .i_branch_addr(i_branch_addr),
        .o_imem_addr_r(o_imem_addr_r),
        .o_imem_req_r (o_imem_req_r),
        .i_imem_rdata (i_imem_rdata),
        .i_imem_ack   (i_imem_ack),
        .o_ir_r       (o_ir_r),
        .o_pc_r       (o_pc_r),
        .o_ir_valid_r (o_ir_valid_r)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memWord(input logic [31:0] a);
        return a[16:1] ^ 16'hA5C3;
    endfunction

    function automatic void checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void refillStream();
        while (exp_q.size() < 16) begin
            exp_q.push_back('{pc: next_pc, ir: memWord(next_pc)});
            next_pc = next_pc + 32'd2;
        end
    endfunction

    // Program order restarts at the reset PC or the aligned branch target.
    function automatic void restartStream(input logic [31:0] start);
        exp_q.delete();
        next_pc = start & 32'hFFFF_FFFE;
        refillStream();
    endfunction

    always @(posedge clk) begin
        s_rst   = rst;
        s_mode  = i_mode;
        started = 1'b1;
        if (rst) restartStream(RST_PC);
        else if (i_mode == MODE_BRANCH) restartStream(i_branch_addr);
    end

    // Memory model: acks each request once after a random latency, garbage data otherwise.
    always begin
        @(posedge clk);
        #1;
        if (mem_en) begin
            i_imem_ack   = 1'b0;
            i_imem_rdata = 16'($urandom);
            if (!o_imem_req_r || rst) begin
                counting = 1'b0;
            end else begin
                if (!counting) begin
                    counting = 1'b1;
                    wait_cnt = $urandom_range(lat_max, lat_min);
                end
                if (wait_cnt == 0) begin
                    i_imem_ack   = 1'b1;
                    i_imem_rdata = memWord(o_imem_addr_r);
                    counting     = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (o_imem_req_r && !prev_req) begin
                req_log.push_back(o_imem_addr_r);
                checkOutput("req_addr_even", o_imem_addr_r[0], 1'b0);
            end
            if (o_imem_req_r && prev_req) checkOutput("req_addr_stable", o_imem_addr_r, prev_addr);
            prev_req  = o_imem_req_r;
            prev_addr = o_imem_addr_r;
        end
    end

    // Monitor: every fresh load of a valid instruction must be the next one in program order.
    always @(negedge clk) begin
        if (started) begin
            if (s_rst) begin
                checkOutput("reset_state", {o_ir_r, o_pc_r, o_ir_valid_r, o_imem_req_r, o_imem_addr_r},
                            {NOP, RST_PC, 1'b0, 1'b0, RST_PC});
                model_ir = NOP; model_pc = RST_PC; model_valid = 1'b0;
            end else if (s_mode == MODE_BRANCH) begin
                checkOutput("branch_bubble", {o_ir_r, o_ir_valid_r}, {NOP, 1'b0});
                model_ir = NOP; model_valid = 1'b0;
            end else if (s_mode == MODE_NORMAL) begin
                if (o_ir_valid_r) begin
                    checkOutput("ir_expected_present", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput("ir_load", {o_ir_r, o_pc_r}, {e.ir, e.pc});
                        model_ir = e.ir; model_pc = e.pc; model_valid = 1'b1;
                        delivered++;
                        refillStream();
                    end
                end else begin
                    checkOutput("ir_empty_bubble", o_ir_r, NOP);
                    model_ir = NOP; model_valid = 1'b0;
                end
            end else begin
                checkOutput("stall_hold", {o_ir_r, o_ir_valid_r}, {model_ir, model_valid});
                if (model_valid) checkOutput("stall_hold_pc", o_pc_r, model_pc);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] ba, input int n);
        i_mode = m;
        i_branch_addr = ba;
        repeat (n) align();
    endtask

    task automatic resetDut(input int n);
        rst = 1'b1;
        repeat (n) align();
        rst = 1'b0;
    endtask

    // Request-log entries made after this point belong to the branch target stream.
    task automatic branchHere(input logic [31:0] target);
        i_mode = MODE_BRANCH;
        i_branch_addr = target;
        @(negedge clk);
        #1;
        req_log.delete();
        align();
        i_mode = MODE_NORMAL;
    endtask

    task automatic waitReq(input logic level, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            align();
            if (o_imem_req_r == level) ok = 1'b1;
        end
        checkOutput(name, ok, 1'b1);
    endtask

    task automatic checkReqLog(input string name, input int idx, input logic [31:0] exp);
        checkOutput({name, "_present"}, req_log.size() > idx, 1'b1);
        if (req_log.size() > idx) checkOutput(name, req_log[idx], exp);
    endtask

    initial begin
        align();
        req_log.delete();
        resetDut(3);
        applyStimulus(MODE_NORMAL, 32'h0, 30);
        checkReqLog("wrap_addr0", 0, 32'hFFFF_FFFC);
        checkReqLog("wrap_addr1", 1, 32'hFFFF_FFFE);
        checkReqLog("wrap_addr2", 2, 32'h0000_0000);
        checkOutput("startup_delivered", delivered >= 5, 1'b1);

        branchHere(32'h0000_0000);
        applyStimulus(MODE_NORMAL, 32'h0, 20);
        checkReqLog("seq_addr0", 0, 32'h0);
        checkReqLog("seq_addr1", 1, 32'h2);
        checkReqLog("seq_addr2", 2, 32'h4);

        applyStimulus(MODE_STALL, 32'h0, 5);
        applyStimulus(MODE_NORMAL, 32'h0, 6);

        branchHere(32'h0000_0040);
        applyStimulus(MODE_STALL, 32'h0, 20);
        checkOutput("stall_fill_reqs", req_log.size(), EXP_DEPTH);
        checkOutput("stall_req_idle", o_imem_req_r, 1'b0);
        applyStimulus(MODE_NORMAL, 32'h0, 20);

        lat_min = 3; lat_max = 3;
        waitReq(1'b0, "drop_req_low");
        waitReq(1'b1, "drop_req_high");
        branchHere(32'h0000_0101);
        applyStimulus(MODE_NORMAL, 32'h0, 30);
        checkReqLog("drop_target", 0, 32'h0000_0100);

        lat_min = 1; lat_max = 1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                align();
                if (i_imem_ack) seen = 1'b1;
            end
            checkOutput("ack_seen", seen, 1'b1);
        end
        branchHere(32'h0000_0200);
        applyStimulus(MODE_NORMAL, 32'h0, 20);
        checkReqLog("ackbranch_target", 0, 32'h0000_0200);

        lat_min = 2; lat_max = 2;
        waitReq(1'b0, "rst_req_low");
        waitReq(1'b1, "rst_req_high");
        mem_en = 1'b0;
        i_imem_ack = 1'b0;
        rst = 1'b1;
        align();
        align();
        i_imem_ack = 1'b1;
        i_imem_rdata = 16'h1234;
        align();
        i_imem_ack = 1'b0;
        align();
        rst = 1'b0;
        mem_en = 1'b1;
        req_log.delete();
        applyStimulus(MODE_NORMAL, 32'h0, 15);
        checkReqLog("post_reset_addr", 0, RST_PC);

        lat_min = 0; lat_max = 2;
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(99, 0);
            if (r < 60) begin
                applyStimulus(MODE_NORMAL, 32'h0, $urandom_range(4, 1));
            end else if (r < 88) begin
                applyStimulus(MODE_STALL, 32'h0, $urandom_range(4, 1));
            end else if ($urandom_range(9, 0) == 0) begin
                applyStimulus(MODE_BRANCH, 32'hFFFF_FFF0 + 32'($urandom_range(15, 0)), 1);
            end else begin
                applyStimulus(MODE_BRANCH, 32'($urandom_range(4095, 0)), 1);
            end
        end
        applyStimulus(MODE_NORMAL, 32'h0, 10);
        checkOutput("overall_delivered", delivered >= 60, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
